// File: rtl/porta_pkg.sv
// rtl/porta_pkg.sv - shared state encoding and status glyphs for the door lock
package porta_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ENTRY,
        ST_OPEN,
        ST_LOCKOUT
    } state_t;

    // Seven-segment patterns, active low, hex[6]=g .. hex[0]=a
    localparam logic [6:0] SEG_DASH = 7'b0111111;
    localparam logic [6:0] SEG_A    = 7'b0001000;
    localparam logic [6:0] SEG_E    = 7'b0000110;

endpackage

// File: rtl/porta_hex7seg.sv
// rtl/porta_hex7seg.sv - 4-bit value to active-low seven-segment glyph
module porta_hex7seg (
    input  logic [3:0] value,
    output logic [6:0] seg
);

    always_comb begin
        seg = 7'b1111111;
        case (value)
            4'h0: seg = 7'b1000000;
            4'h1: seg = 7'b1111001;
            4'h2: seg = 7'b0100100;
            4'h3: seg = 7'b0110000;
            4'h4: seg = 7'b0011001;
            4'h5: seg = 7'b0010010;
            4'h6: seg = 7'b0000010;
            4'h7: seg = 7'b1111000;
            4'h8: seg = 7'b0000000;
            4'h9: seg = 7'b0010000;
            4'hA: seg = 7'b0001000;
            4'hB: seg = 7'b0000011;
            4'hC: seg = 7'b1000110;
            4'hD: seg = 7'b0100001;
            4'hE: seg = 7'b0000110;
            4'hF: seg = 7'b0001110;
            default: seg = 7'b1111111;
        endcase
    end

endmodule

// File: rtl/porta_fechadura.sv
// rtl/porta_fechadura.sv - three-digit door lock with open window and failure lockout
module porta_fechadura
    import porta_pkg::*;
#(
    parameter logic [11:0] CODE      = 12'h3A7,
    parameter int          MAX_FAIL  = 3,
    parameter int          OPEN_TIME = 16,
    parameter int          LOCK_TIME = 32
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       enter,
    input  logic [3:0] digit,
    output logic       led_verde,
    output logic       led_vermelho,
    output logic [6:0] hex
);

    localparam int TMAX = (OPEN_TIME > LOCK_TIME) ? OPEN_TIME : LOCK_TIME;
    localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [TW-1:0] OPEN_LOAD = TW'(OPEN_TIME - 1);
    localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_TIME - 1);
    localparam logic [2:0]    FAIL_LIM  = 3'(MAX_FAIL);

    state_t         state, state_n;
    logic [1:0]     idx, idx_n;
    logic           mismatch, mismatch_n;
    logic [2:0]     fail_cnt, fail_cnt_n;
    logic [TW-1:0]  timer, timer_n;
    logic [3:0]     last_digit, last_digit_n;
    logic           enter_q;
    logic           enter_edge;
    logic           final_mismatch;
    logic [6:0]     digit_seg;

    assign enter_edge = enter & ~enter_q;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            idx        <= '0;
            mismatch   <= 1'b0;
            fail_cnt   <= '0;
            timer      <= '0;
            last_digit <= '0;
            enter_q    <= 1'b0;
        end else begin
            state      <= state_n;
            idx        <= idx_n;
            mismatch   <= mismatch_n;
            fail_cnt   <= fail_cnt_n;
            timer      <= timer_n;
            last_digit <= last_digit_n;
            enter_q    <= enter;
        end
    end

    always_comb begin
        state_n        = state;
        idx_n          = idx;
        mismatch_n     = mismatch;
        fail_cnt_n     = fail_cnt;
        timer_n        = timer;
        last_digit_n   = last_digit;
        final_mismatch = mismatch | (digit != CODE[3:0]);
        case (state)
            ST_IDLE: begin
                if (enter_edge) begin
                    last_digit_n = digit;
                    mismatch_n   = (digit != CODE[11:8]);
                    idx_n        = 2'd1;
                    state_n      = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (enter_edge) begin
                    last_digit_n = digit;
                    if (idx == 2'd1) begin
                        mismatch_n = mismatch | (digit != CODE[7:4]);
                        idx_n      = 2'd2;
                    end else begin
                        mismatch_n = final_mismatch;
                        if (!final_mismatch) begin
                            state_n    = ST_OPEN;
                            timer_n    = OPEN_LOAD;
                            fail_cnt_n = '0;
                        end else if (fail_cnt + 3'd1 == FAIL_LIM) begin
                            state_n = ST_LOCKOUT;
                            timer_n = LOCK_LOAD;
                            idx_n   = '0;
                        end else begin
                            fail_cnt_n = fail_cnt + 3'd1;
                            state_n    = ST_IDLE;
                            idx_n      = '0;
                        end
                    end
                end
            end
            // Countdown states ignore enter entirely; the window length is fixed
            ST_OPEN, ST_LOCKOUT: begin
                if (timer == '0) begin
                    state_n    = ST_IDLE;
                    idx_n      = '0;
                    mismatch_n = 1'b0;
                    if (state == ST_LOCKOUT) begin
                        fail_cnt_n = '0;
                    end
                end else begin
                    timer_n = timer - TW'(1);
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    porta_hex7seg u_hex (
        .value (last_digit),
        .seg   (digit_seg)
    );

    always_comb begin
        led_verde    = 1'b0;
        led_vermelho = 1'b1;
        hex          = SEG_DASH;
        case (state)
            ST_ENTRY:   hex = digit_seg;
            ST_OPEN: begin
                led_verde    = 1'b1;
                led_vermelho = 1'b0;
                hex          = SEG_A;
            end
            ST_LOCKOUT: hex = SEG_E;
            default:    hex = SEG_DASH;
        endcase
    end

endmodule

// File: tb/tb_porta_fechadura.sv
// tb/tb_porta_fechadura.sv - directed plus randomized bench for porta_fechadura
module tb_porta_fechadura;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       enter;
    logic [3:0] digit;
    logic       led_verde;
    logic       led_vermelho;
    logic [6:0] hex;

    always #5 clock = ~clock;

    porta_fechadura #(
        .CODE      (12'h3A7),
        .MAX_FAIL  (3),
        .OPEN_TIME (16),
        .LOCK_TIME (32)
    ) dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .enter        (enter),
        .digit        (digit),
        .led_verde    (led_verde),
        .led_vermelho (led_vermelho),
        .hex          (hex)
    );

    int checks = 0;
    int failures = 0;

    logic [11:0] code = 12'h3A7;
    logic [6:0]  gly [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                              7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                              7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                              7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

    // Reference: digits typed so far, remaining open/lockout cycles, consecutive failures
    logic [3:0] typed [$];
    int         open_left;
    int         lock_left;
    int         fails;
    logic       prev_en;

    function automatic void model_reset();
        typed.delete();
        open_left = 0;
        lock_left = 0;
        fails     = 0;
        prev_en   = 1'b0;
    endfunction

    function automatic void model_step(input logic e, input logic [3:0] d);
        logic edg;
        edg = e & ~prev_en;
        prev_en = e;
        if (open_left > 0) begin
            open_left--;
        end else if (lock_left > 0) begin
            lock_left--;
            if (lock_left == 0) fails = 0;
        end else if (edg) begin
            typed.push_back(d);
            if (typed.size() == 3) begin
                if (typed[0] == code[11:8] && typed[1] == code[7:4] && typed[2] == code[3:0]) begin
                    open_left = 16;
                    fails = 0;
                end else begin
                    fails++;
                    if (fails == 3) lock_left = 32;
                end
                typed.delete();
            end
        end
    endfunction

    function automatic logic [3:0] next_code_digit();
        case (typed.size())
            0:       return code[11:8];
            1:       return code[7:4];
            default: return code[3:0];
        endcase
    endfunction

    task automatic check(input string tag);
        logic       ev, er;
        logic [6:0] eh;
        if (open_left > 0) begin
            ev = 1'b1; er = 1'b0; eh = 7'b0001000;
        end else if (lock_left > 0) begin
            ev = 1'b0; er = 1'b1; eh = 7'b0000110;
        end else if (typed.size() == 0) begin
            ev = 1'b0; er = 1'b1; eh = 7'b0111111;
        end else begin
            ev = 1'b0; er = 1'b1; eh = gly[typed[typed.size()-1]];
        end
        checks++;
        assert (led_verde === ev && led_vermelho === er && hex === eh) else begin
            failures++;
            $error("FAIL %s: got verde=%b vermelho=%b hex=%b, expected verde=%b vermelho=%b hex=%b",
                   tag, led_verde, led_vermelho, hex, ev, er, eh);
        end
    endtask

    task automatic check_int(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic check_hex(input string tag, input logic [6:0] exp);
        checks++;
        assert (hex === exp) else begin
            failures++;
            $error("FAIL %s: got hex=%b, expected hex=%b", tag, hex, exp);
        end
    endtask

    task automatic cyc(input logic e, input logic [3:0] d, input string tag);
        enter = e;
        digit = d;
        @(posedge clock);
        model_step(e, d);
        @(negedge clock);
        check(tag);
    endtask

    task automatic press(input logic [3:0] d, input string tag);
        cyc(1'b1, d, tag);
        cyc(1'b0, d, tag);
    endtask

    task automatic idle(input int n, input string tag);
        for (int i = 0; i < n; i++) cyc(1'b0, 4'h0, tag);
    endtask

    // Runs n cycles (optionally pulsing enter) and counts cycles showing the given glyph
    task automatic count_glyph(input int n, input logic pulse, input logic [6:0] g, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            cyc(pulse & logic'(i % 2), 4'($urandom_range(0, 15)), "count_window");
            if (hex === g) cnt++;
        end
    endtask

    int cnt;
    logic       re;
    logic [3:0] rd;

    initial begin
        reset_n = 1'b0;
        enter   = 1'b0;
        digit   = 4'h5;
        model_reset();
        #12;
        check("reset_state");
        @(negedge clock);
        check("reset_held");
        reset_n = 1'b1;
        idle(5, "idle_hold");

        // Correct code, open window length
        press(4'h3, "first_digit");
        check_hex("glyph_3", 7'b0110000);
        press(4'hA, "second_digit");
        check_hex("glyph_A", 7'b0001000);
        cyc(1'b1, 4'h7, "third_digit");
        cnt = (led_verde === 1'b1) ? 1 : 0;
        for (int i = 0; i < 19; i++) begin
            cyc(1'b0, 4'h7, "open_window");
            if (led_verde === 1'b1) cnt++;
        end
        check_int("open_cycles", cnt, 16);

        // One wrong attempt, then a correct one resets the failure count
        press(4'h3, "wrong_a"); press(4'hA, "wrong_a"); press(4'h6, "wrong_a");
        check_hex("dash_after_wrong", 7'b0111111);
        press(4'h3, "retry"); press(4'hA, "retry"); press(4'h7, "retry");
        idle(16, "retry_open");
        press(4'h0, "f1"); press(4'h0, "f1"); press(4'h0, "f1");
        press(4'h0, "f2"); press(4'h0, "f2"); press(4'h0, "f2");
        check_hex("no_lock_after_two", 7'b0111111);

        // Third consecutive failure locks out; pulses in lockout are ignored
        press(4'h0, "f3"); press(4'h0, "f3");
        cyc(1'b1, 4'h0, "f3_last");
        cnt = (hex === 7'b0000110) ? 1 : 0;
        count_glyph(40, 1'b1, 7'b0000110, cnt);
        check_int("lock_cycles", cnt + ((cnt >= 0) ? 1 : 0), 32);
        press(4'h3, "post_lock"); press(4'hA, "post_lock"); press(4'h7, "post_lock");
        idle(16, "post_lock_open");

        // Held enter counts once; pulses during open do not extend the window
        for (int i = 0; i < 10; i++) cyc(1'b1, 4'h3, "held_enter");
        cyc(1'b0, 4'h3, "held_release");
        press(4'hA, "after_hold");
        check_hex("held_counted_once", 7'b0001000);
        cyc(1'b1, 4'h7, "after_hold_third");
        count_glyph(20, 1'b1, 7'b0001000, cnt);
        check_int("open_with_pulses", cnt + 1, 16);

        // Asynchronous reset mid-entry; enter high at release gives one edge
        press(4'h3, "pre_reset"); press(4'hA, "pre_reset");
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check("async_reset");
        @(posedge clock);
        @(negedge clock);
        check("reset_low_hold");
        enter   = 1'b1;
        digit   = 4'h7;
        reset_n = 1'b1;
        cyc(1'b1, 4'h7, "edge_at_release");
        cyc(1'b0, 4'h7, "edge_at_release");
        press(4'h3, "after_reset"); press(4'hA, "after_reset");
        idle(3, "after_reset_fail");
        press(4'h3, "full_seq"); press(4'hA, "full_seq"); press(4'h7, "full_seq");
        idle(18, "full_seq_open");

        // Randomized traffic biased toward the correct code
        for (int i = 0; i < 3000; i++) begin
            re = logic'($urandom_range(0, 1));
            rd = ($urandom_range(0, 3) != 0) ? next_code_digit() : 4'($urandom_range(0, 15));
            cyc(re, rd, "random");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("FAIL timeout: simulation did not finish, failures=%0d", failures);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "timeout");
    end

endmodule

// File: doc/porta_fechadura.md
Name: porta_fechadura

Overview:
- Clocked digital door lock ("Sistema Porta") for the lab board.
- User keys 4-bit digits on switches and confirms each one with an enter switch.
- After three digits: correct code opens the door (green LED); wrong code keeps it locked (red LED); repeated failures trigger a timed lockout.
- A seven-segment display shows the last digit entered or a status glyph.

Parameters:
- CODE, 12'h3A7: expected sequence; first digit CODE[11:8], second CODE[7:4], third CODE[3:0].
- MAX_FAIL, 3: consecutive failed attempts that trigger lockout (range 1..7).
- OPEN_TIME, 16: cycles the door stays open.
- LOCK_TIME, 32: cycles of lockout.

Ports:
- clock  in  1  system clock; all state changes on the rising edge.
- reset_n  in  1  asynchronous, active-low reset.
- enter  in  1  confirm switch; level input, rising edge used.
- digit  in  4  digit value 0..F; sampled on the cycle an enter edge is detected.
- led_verde  out  1  green LED, 1 = door open.
- led_vermelho  out  1  red LED, 1 = door locked.
- hex  out  7  seven-segment, active low; hex[6]=g .. hex[0]=a.

Behaviour:
- Edge detect: enter_q <= enter each cycle, reset value 0.
  - edge = enter & ~enter_q.
  - Holding enter high counts once.
  - enter already high at reset release still produces one edge on the first cycle.
- Registers:
  - state: IDLE, ENTRY, OPEN, LOCKOUT.
  - idx, 2 bits.
  - mismatch, 1 bit.
  - fail_cnt, 3 bits.
  - timer, wide enough for max(OPEN_TIME, LOCK_TIME).
  - last_digit, 4 bits.
- Reset (asynchronous): state=IDLE; idx, mismatch, fail_cnt, timer, last_digit all 0.
  - Outputs at reset: led_verde=0, led_vermelho=1, hex=7'b0111111 (dash).
- IDLE, on edge:
  - last_digit <= digit.
  - mismatch <= (digit != CODE[11:8]).
  - idx <= 1; go to ENTRY.
- ENTRY, on edge with idx=1: compare against CODE[7:4]; mismatch |= result; idx <= 2.
- ENTRY, on edge with idx=2 (third digit): compare against CODE[3:0]; then by final mismatch value:
  - 0: go to OPEN; timer <= OPEN_TIME-1; fail_cnt <= 0.
  - 1 and fail_cnt+1 == MAX_FAIL: go to LOCKOUT; timer <= LOCK_TIME-1.
  - 1 otherwise: fail_cnt++; go to IDLE.
  - Going to IDLE or LOCKOUT clears idx.
- No edge in IDLE/ENTRY: hold all registers. There is no entry timeout.
- OPEN: timer decrements each cycle; at timer==0, go to IDLE, clearing idx and mismatch. Edges ignored.
- LOCKOUT: same countdown. On exit to IDLE, fail_cnt <= 0. Edges ignored.
- Outputs are a Moore decode of registered state, so they change on the same clock edge as the state:
  - IDLE: verde 0, vermelho 1, hex dash.
  - ENTRY: verde 0, vermelho 1, hex = glyph(last_digit).
  - OPEN: verde 1, vermelho 0, hex "A" 7'b0001000.
  - LOCKOUT: verde 0, vermelho 1, hex "E" 7'b0000110.
- Latency: an edge sampled in cycle k is visible on the outputs after the rising edge ending cycle k.
- OPEN lasts exactly OPEN_TIME cycles; LOCKOUT lasts exactly LOCK_TIME cycles.
- Glyphs, active low, standard hex font:
  - 0 = 1000000, 1 = 1111001, 2 = 0100100, 3 = 0110000, 4 = 0011001, 5 = 0010010, 6 = 0000010, 7 = 1111000,
  - 8 = 0000000, 9 = 0010000, A = 0001000, b = 0000011, C = 1000110, d = 0100001, E = 0000110, F = 0001110.
- led_verde and led_vermelho are never both 1 and never both 0.
- Reset mid-entry or mid-countdown returns everything to reset values immediately.

Decomposition:
- Package porta_pkg holds:
  - state enum.
  - segment constants SEG_DASH, SEG_A, SEG_E.
- Sub-module porta_hex7seg: combinational 4-bit-to-7-segment active-low decoder. Used for digit glyphs; the status glyphs come from the package constants.

Test Plan:
- Reset, with enter=0 and digit=5: outputs 0/1/0111111. Release reset, hold 5 cycles → unchanged.
- Enter 3, A, 7 (default CODE), one enter pulse each.
  - hex shows 0110000, then 0001000.
  - After the third edge: verde=1, vermelho=0, hex=0001000 for exactly 16 cycles, then the IDLE outputs return.
- Enter 3, A, 6 → IDLE outputs (dash), fail_cnt=1. Then 3, A, 7 → OPEN, fail_cnt=0.
- Three wrong attempts (0,0,0 ×3) → LOCKOUT: hex 0000110, vermelho=1 for exactly 32 cycles.
  - Enter pulses during lockout ignored.
  - After lockout, a correct code opens.
- Hold enter high 10 cycles with digit=3 → idx advances only once.
  - Pulses during OPEN do not extend or alter the 16-cycle window.
- Assert reset_n=0 asynchronously after two correct digits → outputs at reset values immediately.
  - After release, only a full 3-digit sequence opens.
